regfile_mp: RTL and testbench

Parametrised multi-port register file for the datapath: NREGS registers of WIDTH bits, one write port, two independent read ports, write-to-read bypass, selectable combinational or registered read, and a per-register busy scoreboard. It replaces the fixed 8×16, single-read-port register file. The controller FSM uses the scoreboard to stall on registers whose result is still pending.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_mp_reg_load.sv | 24 ++
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry and read-mode selectors.
package regfile_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;

  localparam int RD_COMB = 0;
  localparam int RD_REGD = 1;

endpackage

// File: rtl/regfile_mp_reg_load.sv
// Single storage register with load enable and asynchronous active-low clear.
module reg_load #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/regfile_mp.sv
// NREGS x WIDTH register file: one write port, two read ports with write bypass,
// optional registered read, and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int RD_REG = RD_COMB,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write,
  input  logic [AW-1:0]    writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             lock,
  input  logic [AW-1:0]    locknum,
  output logic [NREGS-1:0] busy,
  output logic             busy_a,
  output logic             busy_b
);

  localparam logic [AW:0] NREGS_C = (AW + 1)'(NREGS);

  logic             wr_ok, lk_ok, ra_ok, rb_ok;
  logic [WIDTH-1:0] reg_val [NREGS];
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [NREGS-1:0] busy_q, busy_d;

  // Index checks only matter when NREGS is not a power of two.
  assign wr_ok = write && ({1'b0, writenum} < NREGS_C);
  assign lk_ok = lock && ({1'b0, locknum} < NREGS_C);
  assign ra_ok = {1'b0, readnum_a} < NREGS_C;
  assign rb_ok = {1'b0, readnum_b} < NREGS_C;

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    reg_load #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk    (clk),
      .reset_n(reset_n),
      .load_i (write && (writenum == AW'(g))),
      .d_i    (data_in),
      .q_o    (reg_val[g])
    );
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    if (ra_ok) begin
      sel_a = (wr_ok && (writenum == readnum_a)) ? data_in : reg_val[readnum_a];
    end
    if (rb_ok) begin
      sel_b = (wr_ok && (writenum == readnum_b)) ? data_in : reg_val[readnum_b];
    end
  end

  // Lock is applied after the write clear so a same-index lock wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[writenum] = 1'b0;
    end
    if (lk_ok) begin
      busy_d[locknum] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign busy_a = ra_ok ? busy_q[readnum_a] : 1'b0;
  assign busy_b = rb_ok ? busy_q[readnum_b] : 1'b0;

  if (RD_REG == RD_REGD) begin : g_rd_reg
    logic [WIDTH-1:0] out_a_q, out_b_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out_a_q <= '0;
        out_b_q <= '0;
      end else begin
        out_a_q <= sel_a;
        out_b_q <= sel_b;
      end
    end

    assign data_out_a = out_a_q;
    assign data_out_b = out_b_q;
  end else begin : g_rd_comb
    assign data_out_a = sel_a;
    assign data_out_b = sel_b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: 8x16 combinational and registered instances share stimulus,
// a 6x8 instance exercises out-of-range indices; all checked against an array model.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 8 x 16 stimulus (shared by comb and registered instances)
  logic        a_wr = 1'b0, a_lk = 1'b0;
  logic [2:0]  a_wn = '0, a_ra = '0, a_rb = '0, a_ln = '0;
  logic [15:0] a_din = '0;
  logic [15:0] a0_out_a, a0_out_b, a1_out_a, a1_out_b;
  logic [7:0]  a0_busy, a1_busy;
  logic        a0_ba, a0_bb, a1_ba, a1_bb;

  // 6 x 8 stimulus
  logic        b_wr = 1'b0, b_lk = 1'b0;
  logic [2:0]  b_wn = '0, b_ra = '0, b_rb = '0, b_ln = '0;
  logic [7:0]  b_din = '0;
  logic [7:0]  b_out_a, b_out_b;
  logic [5:0]  b_busy;
  logic        b_ba, b_bb;

  regfile_mp #(.WIDTH(16), .NREGS(8), .RD_REG(0)) dut_comb (
    .clk(clk), .reset_n(reset_n), .write(a_wr), .writenum(a_wn), .data_in(a_din),
    .readnum_a(a_ra), .readnum_b(a_rb), .data_out_a(a0_out_a), .data_out_b(a0_out_b),
    .lock(a_lk), .locknum(a_ln), .busy(a0_busy), .busy_a(a0_ba), .busy_b(a0_bb)
  );

  regfile_mp #(.WIDTH(16), .NREGS(8), .RD_REG(1)) dut_regd (
    .clk(clk), .reset_n(reset_n), .write(a_wr), .writenum(a_wn), .data_in(a_din),
    .readnum_a(a_ra), .readnum_b(a_rb), .data_out_a(a1_out_a), .data_out_b(a1_out_b),
    .lock(a_lk), .locknum(a_ln), .busy(a1_busy), .busy_a(a1_ba), .busy_b(a1_bb)
  );

  regfile_mp #(.WIDTH(8), .NREGS(6), .RD_REG(0)) dut_np2 (
    .clk(clk), .reset_n(reset_n), .write(b_wr), .writenum(b_wn), .data_in(b_din),
    .readnum_a(b_ra), .readnum_b(b_rb), .data_out_a(b_out_a), .data_out_b(b_out_b),
    .lock(b_lk), .locknum(b_ln), .busy(b_busy), .busy_a(b_ba), .busy_b(b_bb)
  );

  // Reference model
  logic [15:0] ma [8];
  logic [7:0]  ma_busy = '0;
  logic [7:0]  mb [6];
  logic [5:0]  mb_busy = '0;
  logic [15:0] exp1_a = '0, exp1_b = '0, nxt1_a, nxt1_b;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rd_a(input logic [2:0] idx);
    if (a_wr && a_wn == idx) return a_din;
    return ma[idx];
  endfunction

  function automatic logic [7:0] rd_b(input logic [2:0] idx);
    if (idx >= 3'd6) return 8'h00;
    if (b_wr && b_wn == idx) return b_din;
    return mb[idx];
  endfunction

  function automatic logic bz_b(input logic [2:0] idx);
    if (idx >= 3'd6) return 1'b0;
    return mb_busy[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ma[i] = '0;
    for (int i = 0; i < 6; i++) mb[i] = '0;
    ma_busy = '0;
    mb_busy = '0;
    exp1_a  = '0;
    exp1_b  = '0;
  endtask

  task automatic model_edge();
    if (a_wr) begin ma[a_wn] = a_din; ma_busy[a_wn] = 1'b0; end
    if (a_lk) ma_busy[a_ln] = 1'b1;
    if (b_wr && b_wn < 3'd6) begin mb[b_wn] = b_din; mb_busy[b_wn] = 1'b0; end
    if (b_lk && b_ln < 3'd6) mb_busy[b_ln] = 1'b1;
  endtask

  // Inputs are driven by the caller just after a rising edge; checks run mid-cycle and after the edge.
  task automatic tick();
    @(negedge clk);
    #1;
    check("comb_out_a", 32'(a0_out_a), 32'(rd_a(a_ra)));
    check("comb_out_b", 32'(a0_out_b), 32'(rd_a(a_rb)));
    check("comb_busy", 32'(a0_busy), 32'(ma_busy));
    check("comb_busy_a", 32'(a0_ba), 32'(ma_busy[a_ra]));
    check("comb_busy_b", 32'(a0_bb), 32'(ma_busy[a_rb]));
    check("regd_hold_a", 32'(a1_out_a), 32'(exp1_a));
    check("regd_hold_b", 32'(a1_out_b), 32'(exp1_b));
    check("regd_busy", 32'(a1_busy), 32'(ma_busy));
    check("np2_out_a", 32'(b_out_a), 32'(rd_b(b_ra)));
    check("np2_out_b", 32'(b_out_b), 32'(rd_b(b_rb)));
    check("np2_busy", 32'(b_busy), 32'(mb_busy));
    check("np2_busy_a", 32'(b_ba), 32'(bz_b(b_ra)));
    check("np2_busy_b", 32'(b_bb), 32'(bz_b(b_rb)));
    nxt1_a = rd_a(a_ra);
    nxt1_b = rd_a(a_rb);
    @(posedge clk);
    #1;
    model_edge();
    exp1_a = nxt1_a;
    exp1_b = nxt1_b;
    check("regd_out_a", 32'(a1_out_a), 32'(exp1_a));
    check("regd_out_b", 32'(a1_out_b), 32'(exp1_b));
  endtask

  task automatic idle();
    a_wr = 1'b0; a_lk = 1'b0;
    b_wr = 1'b0; b_lk = 1'b0;
  endtask

  initial begin
    model_clear();
    #12 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset clears contents immediately, mid-cycle
    a_wr = 1'b1; a_wn = 3'd3; a_din = 16'hBEEF; a_lk = 1'b1; a_ln = 3'd4;
    tick();
    idle(); a_ra = 3'd3; a_rb = 3'd4;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("rst_comb_a", 32'(a0_out_a), 32'h0);
    check("rst_regd_a", 32'(a1_out_a), 32'h0);
    check("rst_busy", 32'(a0_busy), 32'h0);
    check("rst_np2_busy", 32'(b_busy), 32'h0);
    a_wr = 1'b1; a_wn = 3'd3; a_din = 16'h7777;
    @(posedge clk);
    #1;
    a_wr = 1'b0;
    #1;
    check("rst_wr_ignored", 32'(a0_out_a), 32'h0);
    check("rst_regd_held", 32'(a1_out_a), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    tick();

    // Two-port read
    a_wr = 1'b1; a_wn = 3'd1; a_din = 16'h1234; tick();
    a_wn = 3'd6; a_din = 16'hA5A5; tick();
    idle(); a_ra = 3'd1; a_rb = 3'd6; tick();

    // Bypass
    a_wr = 1'b1; a_wn = 3'd2; a_din = 16'h0001; tick();
    a_din = 16'h00FF; a_ra = 3'd2; tick();
    idle(); tick();

    // Scoreboard
    a_lk = 1'b1; a_ln = 3'd5; a_rb = 3'd5; tick();
    idle(); tick();
    a_wr = 1'b1; a_wn = 3'd5; a_din = 16'h0042; tick();
    idle(); tick();
    a_wr = 1'b1; a_wn = 3'd5; a_din = 16'h0BAD; a_lk = 1'b1; a_ln = 3'd5; a_ra = 3'd5; tick();
    idle(); tick();
    a_wr = 1'b1; a_wn = 3'd0; a_din = 16'h1111; a_lk = 1'b1; a_ln = 3'd7; tick();
    idle(); tick();

    // Registered latency on index change
    a_ra = 3'd1; tick();
    a_ra = 3'd6; tick();

    // Out-of-range on 6-entry instance
    b_wr = 1'b1; b_wn = 3'd2; b_din = 8'h3C; tick();
    b_wn = 3'd7; b_din = 8'hFF; b_ra = 3'd7; b_rb = 3'd2; tick();
    idle(); b_wr = 1'b1; b_wn = 3'd6; b_din = 8'hEE; b_ra = 3'd6; tick();
    idle(); b_lk = 1'b1; b_ln = 3'd7; tick();
    idle(); b_lk = 1'b1; b_ln = 3'd5; b_ra = 3'd5; b_rb = 3'd6; tick();
    idle(); tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      a_wr  = 1'($urandom_range(0, 1));
      a_wn  = 3'($urandom_range(0, 7));
      a_din = 16'($urandom);
      a_lk  = ($urandom_range(0, 3) == 0);
      a_ln  = ($urandom_range(0, 3) == 0) ? a_wn : 3'($urandom_range(0, 7));
      a_ra  = ($urandom_range(0, 2) == 0) ? a_wn : 3'($urandom_range(0, 7));
      a_rb  = ($urandom_range(0, 2) == 0) ? a_wn : 3'($urandom_range(0, 7));
      b_wr  = 1'($urandom_range(0, 1));
      b_wn  = 3'($urandom_range(0, 7));
      b_din = 8'($urandom);
      b_lk  = ($urandom_range(0, 3) == 0);
      b_ln  = 3'($urandom_range(0, 7));
      b_ra  = ($urandom_range(0, 2) == 0) ? b_wn : 3'($urandom_range(0, 7));
      b_rb  = 3'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
